// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - Instruction fetch sequencer: PC, ROM read, fetch FIFO and issue handshake.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          ROM_BYTES = 100,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rom_nrd,
    output logic [31:0]                rom_addr,
    input  logic [31:0]                rom_data,
    output logic                       issue_valid,
    output logic [31:0]                issue_instr,
    output logic [31:0]                issue_pc,
    input  logic                       issue_ready,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       halted
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [31:0] ROM_LIMIT = 32'(ROM_BYTES);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_END   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     pc;
    logic [31:0]     pc_next;
    logic [CW-1:0]   count_next;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [31:0]     mem_instr [DEPTH];
    logic [31:0]     mem_pc    [DEPTH];
    logic            fetch_en;
    logic            pop;

    function automatic logic in_rom(input logic [31:0] addr);
        return (addr + 32'd3) < ROM_LIMIT;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state is judged on the post-update pc and count
    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = in_rom(pc_next) ? S_FETCH : S_END;
        end else if (state == S_END) begin
            state_next = S_END;
        end else if (!in_rom(pc_next)) begin
            state_next = S_END;
        end else if (count_next == FULL_COUNT) begin
            state_next = S_FULL;
        end else begin
            state_next = S_FETCH;
        end
    end

    // Outputs decoded from state; rst gates the ROM strobe while held
    always_comb begin
        fetch_en = 1'b0;
        if (!rst && state == S_FETCH && !redirect && count < FULL_COUNT && in_rom(pc)) begin
            fetch_en = 1'b1;
        end
        rom_nrd = ~fetch_en;
        halted  = (state == S_END);
    end

    assign pop = (count != '0) & issue_ready & ~redirect;

    always_comb begin
        pc_next    = pc;
        count_next = count;
        if (redirect) begin
            pc_next    = redirect_pc & 32'hFFFF_FFFC;
            count_next = '0;
        end else begin
            if (fetch_en) begin
                pc_next = pc + 32'd4;
            end
            count_next = count + CW'(fetch_en) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            count <= '0;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= 32'd0;
                mem_pc[i]    <= 32'd0;
            end
        end else begin
            pc    <= pc_next;
            count <= count_next;
            if (redirect) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (pop) begin
                    head <= head + AW'(1);
                end
                if (fetch_en) begin
                    mem_instr[tail] <= rom_data;
                    mem_pc[tail]    <= pc;
                    tail            <= tail + AW'(1);
                end
            end
        end
    end

    assign rom_addr    = pc;
    assign issue_valid = (count != '0);
    assign issue_instr = mem_instr[head];
    assign issue_pc    = mem_pc[head];

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - Randomized and directed bench for fetch_queue against a queue-based model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int ROM_BYTES = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_nrd;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic        issue_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [2:0]  count;
    logic        halted;

    int checks = 0;
    int failures = 0;

    logic [7:0]  rom [ROM_BYTES];
    logic [63:0] mq [$];
    logic [31:0] mpc = 32'd0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .ROM_BYTES(ROM_BYTES), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst), .rom_nrd(rom_nrd), .rom_addr(rom_addr), .rom_data(rom_data),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_pc(issue_pc),
        .issue_ready(issue_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .count(count), .halted(halted)
    );

    function automatic logic fits(input logic [31:0] a);
        return (a + 32'd3) < 32'(ROM_BYTES);
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (!fits(a)) return 32'hDEAD_BEEF;
        return {rom[a], rom[a+1], rom[a+2], rom[a+3]};
    endfunction

    always_comb rom_data = rom_word(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic exp_fetch;
        exp_fetch = !rst && !redirect && mq.size() < DEPTH && fits(mpc);
        check("rom_nrd", 32'(rom_nrd), 32'(!exp_fetch));
        check("rom_addr", rom_addr, mpc);
        check("issue_valid", 32'(issue_valid), 32'(mq.size() != 0));
        check("count", 32'(count), 32'(mq.size()));
        check("halted", 32'(halted), 32'(!fits(mpc)));
        if (mq.size() != 0) begin
            check("issue_pc", issue_pc, mq[0][63:32]);
            check("issue_instr", issue_instr, mq[0][31:0]);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = 32'd0;
    endtask

    task automatic model_edge();
        logic fe;
        logic pp;
        if (rst) return;
        if (redirect) begin
            mq.delete();
            mpc = redirect_pc & ~32'd3;
        end else begin
            fe = mq.size() < DEPTH && fits(mpc);
            pp = mq.size() != 0 && issue_ready;
            if (pp) void'(mq.pop_front());
            if (fe) begin
                mq.push_back({mpc, rom_word(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [31:0] rp, input logic rdy);
        @(negedge clk);
        rst = r;
        redirect = rd;
        redirect_pc = rp;
        issue_ready = rdy;
        if (r) model_reset();
        #1;
        compare();
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        for (int i = 0; i < ROM_BYTES; i++) rom[i] = 8'($urandom);

        // Reset and streaming
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        #1;
        check("reset_nrd", 32'(rom_nrd), 32'd1);
        check("reset_count", 32'(count), 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        #1;
        check("stream_pc", issue_pc, 32'd20);
        check("stream_instr", issue_instr, {rom[20], rom[21], rom[22], rom[23]});
        check("stream_count", 32'(count), 32'd1);

        // Backpressure
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        #1;
        check("bp_count", 32'(count), 32'd4);
        check("bp_nrd", 32'(rom_nrd), 32'd1);
        check("bp_head0", issue_pc, 32'd0);
        step(0, 0, 0, 1);
        #1;
        check("bp_resume_nrd", 32'(rom_nrd), 32'd0);
        check("bp_resume_addr", rom_addr, 32'd16);
        for (int i = 1; i < 4; i++) begin
            check("bp_head", issue_pc, 32'(4 * i));
            step(0, 0, 0, 1);
            #1;
        end

        // Redirect mid-stream
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        #1;
        check("rd_pre_count", 32'(count), 32'd3);
        step(0, 1, 32'h22, 0);
        #1;
        check("rd_count", 32'(count), 32'd0);
        check("rd_valid", 32'(issue_valid), 32'd0);
        step(0, 0, 0, 1);
        #1;
        check("rd_new_pc", issue_pc, 32'h20);

        // End of ROM with drain
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 23; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        #1;
        check("end_halted", 32'(halted), 32'd1);
        check("end_nrd", 32'(rom_nrd), 32'd1);
        check("end_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        #1;
        check("end_drained", 32'(count), 32'd0);
        check("end_last_pc", rom_addr, 32'd100);

        // Redirect out of END
        step(0, 1, 32'd8, 0);
        #1;
        check("exit_halted", 32'(halted), 32'd0);
        check("exit_addr", rom_addr, 32'd8);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        #1;
        check("exit_head", issue_pc, 32'd8);
        check("exit_count", 32'(count), 32'd2);

        // Asynchronous reset between edges
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_valid", 32'(issue_valid), 32'd0);
        check("async_addr", rom_addr, 32'd0);
        check("async_nrd", 32'(rom_nrd), 32'd1);
        @(posedge clk);
        step(1, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 24) == 0,
                 32'($urandom_range(0, 120)),
                 $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch sequencer for the Tomasulo core. It owns the program counter and drives the 100-byte combinational instruction ROM, capturing one 32-bit big-endian word per cycle into a small FIFO. It presents that FIFO to the issue stage through a valid/ready handshake. It also handles redirect (branch/flush) and stops fetching at the end of ROM.

## Interface
Parameters:
- DEPTH, 4: FIFO entries (power of two, ≥2).
- ROM_BYTES, 100: ROM size in bytes. A fetch is legal only when pc+3 < ROM_BYTES.
- RESET_PC, 0: PC after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_nrd  out  1  ROM read enable, active low. Combinational from state.
- rom_addr  out  32  byte address to ROM; always equals pc.
- rom_data  in  32  ROM word, valid in the same cycle as rom_nrd=0.
- issue_valid  out  1  FIFO head valid.
- issue_instr  out  32  FIFO head instruction.
- issue_pc  out  32  byte address of the FIFO head instruction.
- issue_ready  in  1  issue stage accepts the head this cycle.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new PC. Bits [1:0] are forced to 0.
- count  out  3  occupied entries, 0..DEPTH. Width is clog2(DEPTH)+1.
- halted  out  1  high in state END.

## Operation
- FSM states:
  - FETCH: reading the ROM.
  - FULL: FIFO full, fetch paused.
  - END: pc past ROM, fetch stopped.
- fetch_en = (state==FETCH) & ~redirect & (count<DEPTH) & (pc+3 < ROM_BYTES). rom_nrd = ~fetch_en.
- On an edge with fetch_en:
  - write {pc, rom_data} at the tail;
  - pc <= pc+4.
- Pop occurs on an edge with issue_valid & issue_ready & ~redirect; the head advances.
- Push eligibility uses count at the start of the cycle. A full FIFO does not push, even when popping in the same cycle.
- Next state, evaluated after pc and count update:
  - END if pc+3 >= ROM_BYTES;
  - else FULL if count==DEPTH;
  - else FETCH.
- END exits only through redirect or rst.
- redirect has highest priority:
  - FIFO emptied (count<=0, head/tail pointers<=0);
  - pc <= {redirect_pc[31:2],2'b00};
  - no push and no pop that cycle;
  - next state is evaluated from the new pc: END if out of range, else FETCH.
- issue_instr and issue_pc come straight from FIFO registers. issue_valid = (count!=0). Both are X-free when invalid (they hold the last head contents).
- PC arithmetic is 32-bit, mod 2^32. Wrap is unreachable because of the ROM_BYTES bound.
- Pointers are clog2(DEPTH) bits and wrap naturally. count tracks fullness.

## Timing
- Reset (async assert, any cycle, including mid-fetch):
  - pc=RESET_PC, count=0, pointers=0, state=FETCH;
  - issue_valid=0, halted=0;
  - rom_nrd=1 while rst is high;
  - rom_addr=RESET_PC.
- First cycle after rst deasserts: rom_nrd=0, rom_addr=RESET_PC. The word is captured at the next edge, and issue_valid=1 in the following cycle. Fetch-to-issue latency is 1 cycle.
- Sustained throughput is 1 instruction/cycle when issue_ready is held high. count stays at 1, with push and pop on every edge.
- Simultaneous push and pop leaves count unchanged.
- Redirect: issue_valid=0 in the cycle after the redirect edge. The first fetch from the new PC happens in that same cycle, so the new instruction is visible 2 cycles after redirect is asserted.
- END: halted=1 and rom_nrd=1. Draining still occurs: the issue stage can pop the remaining entries.

## Test plan
- Reset/stream: rst for 2 cycles, then issue_ready=1. Required:
  - issue_pc sequence 0,4,8,… with one per cycle;
  - issue_instr matches the big-endian ROM words;
  - rom_nrd=1 during reset.
- Backpressure: issue_ready=0 for 10 cycles. Required:
  - count reaches 4 after 4 fetches, state FULL, rom_nrd=1;
  - after releasing issue_ready, the pops return pcs 0,4,8,12 in order, and fetch resumes at pc 16.
- Redirect mid-stream: with count=3, pulse redirect with redirect_pc=0x22. Required:
  - count=0 next cycle;
  - the next fetched issue_pc is 0x20;
  - no pre-redirect entry is ever issued.
- End of ROM: stream from 0 with ROM_BYTES=100. Required:
  - the last fetch is pc 96;
  - halted=1 and rom_nrd=1 afterward;
  - the FIFO still drains to count=0.
- Redirect out of END: while halted, redirect_pc=8. Required: halted=0 and fetch resumes at pc 8.
- Async reset mid-operation: assert rst between edges with count=2. Required: count=0, issue_valid=0, pc=0 immediately, without waiting for a clock edge.
